// File: rtl/lotr_pkg.sv
// Shared opcode and state types for the F2C MMIO path.
// Opcode encodings are fixed by the fabric and must match the responder side.
package lotr_pkg;

   typedef enum logic [1:0] {
      RD     = 2'd0,
      WR     = 2'd1,
      RD_RSP = 2'd2
   } t_opcode;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      REQ      = 2'd1,
      WAIT_RSP = 2'd2,
      RSP      = 2'd3
   } t_f2c_init_state;

   localparam int F2C_INIT_TIMEOUT_DEF = 16;

endpackage

// File: rtl/f2c_mmio_initiator.sv
// Single-outstanding F2C MMIO requester: request issued 1 cycle after core handshake, response to core 1 cycle after match.
// Core is stalled (CoreReqReadyQ500H=0) from acceptance until its response is taken; timeouts and stray responses are counted.
module f2c_mmio_initiator
   import lotr_pkg::*;
#(
   parameter int TIMEOUT_CYC = F2C_INIT_TIMEOUT_DEF,
   parameter int CNT_W       = 8
) (
   input  logic              QClk,
   input  logic              RstQnnnL,
   input  logic              CoreReqValidQ500H,
   output logic              CoreReqReadyQ500H,
   input  logic              CoreReqWrQ500H,
   input  logic [31:0]       CoreReqAddressQ500H,
   input  logic [31:0]       CoreReqDataQ500H,
   output logic              CoreRspValidQ501H,
   input  logic              CoreRspReadyQ501H,
   output logic [31:0]       CoreRspDataQ501H,
   output logic              CoreRspErrQ501H,
   output logic              F2C_ReqValidQ502H,
   output t_opcode           F2C_ReqOpcodeQ502H,
   output logic [31:0]       F2C_ReqAddressQ502H,
   output logic [31:0]       F2C_ReqDataQ502H,
   input  logic              F2C_RspValidQ500H,
   input  t_opcode           F2C_RspOpcodeQ500H,
   input  logic [31:0]       F2C_RspAddressQ500H,
   input  logic [31:0]       F2C_RspDataQ500H,
   output logic              Busy,
   output logic [CNT_W-1:0]  TimeoutCnt,
   output logic [CNT_W-1:0]  StrayRspCnt
);

   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);

   t_f2c_init_state  state;
   logic             wr_q;
   logic [31:0]      addr_q;
   logic [CNT_W-1:0] timer;

   logic             rsp_match;
   logic             rsp_consumed;
   logic             timeout_hit;
   logic             stray_rsp;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   // Stores are also acknowledged with RD_RSP, so the opcode check is the same for both.
   assign rsp_match    = F2C_RspValidQ500H && (F2C_RspOpcodeQ500H == RD_RSP) &&
                         (F2C_RspAddressQ500H == addr_q);
   assign rsp_consumed = (state == WAIT_RSP) && rsp_match;
   assign timeout_hit  = (state == WAIT_RSP) && !rsp_match && (timer == TIMEOUT_LAST);
   assign stray_rsp    = F2C_RspValidQ500H && !rsp_consumed;

   always_ff @(posedge QClk or negedge RstQnnnL) begin
      if (!RstQnnnL) begin
         state               <= IDLE;
         wr_q                <= 1'b0;
         addr_q              <= '0;
         timer               <= '0;
         CoreReqReadyQ500H   <= 1'b1;
         CoreRspValidQ501H   <= 1'b0;
         CoreRspDataQ501H    <= '0;
         CoreRspErrQ501H     <= 1'b0;
         F2C_ReqValidQ502H   <= 1'b0;
         F2C_ReqOpcodeQ502H  <= RD;
         F2C_ReqAddressQ502H <= '0;
         F2C_ReqDataQ502H    <= '0;
         Busy                <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (CoreReqValidQ500H) begin
                  wr_q                <= CoreReqWrQ500H;
                  addr_q              <= CoreReqAddressQ500H;
                  F2C_ReqValidQ502H   <= 1'b1;
                  F2C_ReqOpcodeQ502H  <= CoreReqWrQ500H ? WR : RD;
                  F2C_ReqAddressQ502H <= CoreReqAddressQ500H;
                  F2C_ReqDataQ502H    <= CoreReqWrQ500H ? CoreReqDataQ500H : 32'h0;
                  CoreReqReadyQ500H   <= 1'b0;
                  Busy                <= 1'b1;
                  state               <= REQ;
               end
            end
            REQ: begin
               F2C_ReqValidQ502H   <= 1'b0;
               F2C_ReqOpcodeQ502H  <= RD;
               F2C_ReqAddressQ502H <= '0;
               F2C_ReqDataQ502H    <= '0;
               timer               <= '0;
               state               <= WAIT_RSP;
            end
            WAIT_RSP: begin
               timer <= timer + CNT_W'(1);
               // A match on the last timer cycle takes priority over the timeout.
               if (rsp_match) begin
                  CoreRspValidQ501H <= 1'b1;
                  CoreRspDataQ501H  <= wr_q ? 32'h0 : F2C_RspDataQ500H;
                  CoreRspErrQ501H   <= 1'b0;
                  state             <= RSP;
               end else if (timer == TIMEOUT_LAST) begin
                  CoreRspValidQ501H <= 1'b1;
                  CoreRspDataQ501H  <= 32'h0;
                  CoreRspErrQ501H   <= 1'b1;
                  state             <= RSP;
               end
            end
            RSP: begin
               if (CoreRspReadyQ501H) begin
                  CoreRspValidQ501H <= 1'b0;
                  CoreRspDataQ501H  <= 32'h0;
                  CoreRspErrQ501H   <= 1'b0;
                  CoreReqReadyQ500H <= 1'b1;
                  Busy              <= 1'b0;
                  state             <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge QClk or negedge RstQnnnL) begin
      if (!RstQnnnL) begin
         TimeoutCnt  <= '0;
         StrayRspCnt <= '0;
      end else begin
         if (timeout_hit) TimeoutCnt  <= sat_inc(TimeoutCnt);
         if (stray_rsp)   StrayRspCnt <= sat_inc(StrayRspCnt);
      end
   end

endmodule

// File: tb/tb_f2c_mmio_initiator.sv
// Directed bench for f2c_mmio_initiator: table-driven load/store transactions against a 3-cycle responder,
// plus hand sequences for timeout, address mismatch, backpressure with match/timeout collision and mid-flight reset.
module tb_f2c_mmio_initiator;
   import lotr_pkg::*;

   localparam int TO = 16;
   localparam int CW = 8;

   logic          clk;
   logic          rst_n;
   logic          core_req_vld;
   logic          core_req_rdy;
   logic          core_req_wr;
   logic [31:0]   core_req_addr;
   logic [31:0]   core_req_dat;
   logic          core_rsp_vld;
   logic          core_rsp_rdy;
   logic [31:0]   core_rsp_dat;
   logic          core_rsp_err;
   logic          f2c_req_vld;
   t_opcode       f2c_req_op;
   logic [31:0]   f2c_req_addr;
   logic [31:0]   f2c_req_dat;
   logic          f2c_rsp_vld;
   t_opcode       f2c_rsp_op;
   logic [31:0]   f2c_rsp_addr;
   logic [31:0]   f2c_rsp_dat;
   logic          busy;
   logic [CW-1:0] timeout_cnt;
   logic [CW-1:0] stray_cnt;

   int errors = 0;
   int checks = 0;

   f2c_mmio_initiator #(.TIMEOUT_CYC(TO), .CNT_W(CW)) dut (
      .QClk                (clk),
      .RstQnnnL            (rst_n),
      .CoreReqValidQ500H   (core_req_vld),
      .CoreReqReadyQ500H   (core_req_rdy),
      .CoreReqWrQ500H      (core_req_wr),
      .CoreReqAddressQ500H (core_req_addr),
      .CoreReqDataQ500H    (core_req_dat),
      .CoreRspValidQ501H   (core_rsp_vld),
      .CoreRspReadyQ501H   (core_rsp_rdy),
      .CoreRspDataQ501H    (core_rsp_dat),
      .CoreRspErrQ501H     (core_rsp_err),
      .F2C_ReqValidQ502H   (f2c_req_vld),
      .F2C_ReqOpcodeQ502H  (f2c_req_op),
      .F2C_ReqAddressQ502H (f2c_req_addr),
      .F2C_ReqDataQ502H    (f2c_req_dat),
      .F2C_RspValidQ500H   (f2c_rsp_vld),
      .F2C_RspOpcodeQ500H  (f2c_rsp_op),
      .F2C_RspAddressQ500H (f2c_rsp_addr),
      .F2C_RspDataQ500H    (f2c_rsp_dat),
      .Busy                (busy),
      .TimeoutCnt          (timeout_cnt),
      .StrayRspCnt         (stray_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        wr;
      logic [31:0] addr;
      logic [31:0] dat;
      logic [31:0] rsp_dat;
      t_opcode     exp_op;
      logic [31:0] exp_req_dat;
      logic [31:0] exp_rsp_dat;
   } vec_t;

   vec_t vecs[4];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Presents one request for a single cycle; returns in the REQ cycle.
   task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] dat);
      core_req_vld  = 1'b1;
      core_req_wr   = wr;
      core_req_addr = addr;
      core_req_dat  = dat;
      tick();
      core_req_vld  = 1'b0;
      core_req_dat  = 32'h0;
   endtask

   task automatic respond(input t_opcode op, input logic [31:0] addr, input logic [31:0] dat);
      f2c_rsp_vld  = 1'b1;
      f2c_rsp_op   = op;
      f2c_rsp_addr = addr;
      f2c_rsp_dat  = dat;
      tick();
      f2c_rsp_vld  = 1'b0;
      f2c_rsp_dat  = 32'h0;
   endtask

   task automatic take_rsp();
      core_rsp_rdy = 1'b1;
      tick();
      core_rsp_rdy = 1'b0;
   endtask

   initial begin
      int n;
      logic [31:0] held;

      vecs[0] = '{wr: 1'b0, addr: 32'h0380_0004, dat: 32'hCAFE_0001, rsp_dat: 32'h0000_0155,
                  exp_op: RD, exp_req_dat: 32'h0, exp_rsp_dat: 32'h0000_0155};
      vecs[1] = '{wr: 1'b1, addr: 32'h0380_0000, dat: 32'h0000_00A5, rsp_dat: 32'hDEAD_BEEF,
                  exp_op: WR, exp_req_dat: 32'h0000_00A5, exp_rsp_dat: 32'h0};
      vecs[2] = '{wr: 1'b0, addr: 32'h12C0_0010, dat: 32'h1111_2222, rsp_dat: 32'hFFFF_FFFF,
                  exp_op: RD, exp_req_dat: 32'h0, exp_rsp_dat: 32'hFFFF_FFFF};
      vecs[3] = '{wr: 1'b1, addr: 32'hFF7F_FFFC, dat: 32'h1234_5678, rsp_dat: 32'h0BAD_F00D,
                  exp_op: WR, exp_req_dat: 32'h1234_5678, exp_rsp_dat: 32'h0};

      rst_n         = 1'b0;
      core_req_vld  = 1'b0;
      core_req_wr   = 1'b0;
      core_req_addr = 32'h0;
      core_req_dat  = 32'h0;
      core_rsp_rdy  = 1'b0;
      f2c_rsp_vld   = 1'b0;
      f2c_rsp_op    = RD_RSP;
      f2c_rsp_addr  = 32'h0;
      f2c_rsp_dat   = 32'h0;
      #12;
      check("rst_req_rdy",  32'(core_req_rdy), 32'd1);
      check("rst_rsp_vld",  32'(core_rsp_vld), 32'd0);
      check("rst_req_vld",  32'(f2c_req_vld),  32'd0);
      check("rst_busy",     32'(busy),         32'd0);
      check("rst_to_cnt",   32'(timeout_cnt),  32'd0);
      check("rst_stray",    32'(stray_cnt),    32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // Table: full transactions against a responder answering 3 cycles after the request.
      for (int i = 0; i < 4; i++) begin
         check("vec_req_rdy", 32'(core_req_rdy), 32'd1);
         issue(vecs[i].wr, vecs[i].addr, vecs[i].dat);
         check("vec_req_vld",  32'(f2c_req_vld), 32'd1);
         check("vec_req_op",   32'(f2c_req_op),  32'(vecs[i].exp_op));
         check("vec_req_addr", f2c_req_addr,     vecs[i].addr);
         check("vec_req_dat",  f2c_req_dat,      vecs[i].exp_req_dat);
         check("vec_busy",     32'(busy),        32'd1);
         tick();
         check("vec_req_drop", 32'(f2c_req_vld), 32'd0);
         tick();
         tick();
         respond(RD_RSP, vecs[i].addr, vecs[i].rsp_dat);
         check("vec_rsp_vld",  32'(core_rsp_vld), 32'd1);
         check("vec_rsp_dat",  core_rsp_dat,      vecs[i].exp_rsp_dat);
         check("vec_rsp_err",  32'(core_rsp_err), 32'd0);
         check("vec_rdy_hold", 32'(core_req_rdy), 32'd0);
         take_rsp();
         check("vec_done_vld", 32'(core_rsp_vld), 32'd0);
         check("vec_done_rdy", 32'(core_req_rdy), 32'd1);
         check("vec_done_busy", 32'(busy),        32'd0);
      end
      check("vec_stray", 32'(stray_cnt), 32'd0);

      // Timeout: no response; error appears after TO cycles of WAIT_RSP following the REQ cycle.
      issue(1'b0, 32'h0380_0010, 32'h0);
      check("to_req_vld", 32'(f2c_req_vld), 32'd1);
      n = 0;
      while (!core_rsp_vld && n < 40) begin
         tick();
         n++;
      end
      check("to_latency", n,                  TO + 1);
      check("to_err",     32'(core_rsp_err),  32'd1);
      check("to_dat",     core_rsp_dat,       32'h0);
      check("to_cnt",     32'(timeout_cnt),   32'd1);
      take_rsp();
      repeat (4) tick();
      respond(RD_RSP, 32'h0380_0010, 32'h0000_0099);
      check("late_stray", 32'(stray_cnt),    32'd1);
      tick();
      check("late_no_rsp", 32'(core_rsp_vld), 32'd0);
      check("late_idle",   32'(busy),         32'd0);

      // Address mismatch is stray; correct address on the next cycle completes normally.
      issue(1'b0, 32'h0380_0008, 32'h0);
      tick();
      tick();
      tick();
      respond(RD_RSP, 32'h0380_000C, 32'h0000_0066);
      check("mm_stray",  32'(stray_cnt),    32'd2);
      check("mm_wait",   32'(core_rsp_vld), 32'd0);
      check("mm_busy",   32'(busy),         32'd1);
      respond(RD_RSP, 32'h0380_0008, 32'h0000_0077);
      check("mm_rsp_vld", 32'(core_rsp_vld), 32'd1);
      check("mm_rsp_dat", core_rsp_dat,      32'h0000_0077);
      check("mm_stray2",  32'(stray_cnt),    32'd2);
      take_rsp();

      // Wrong opcode with matching address is stray too; then match lands on the timeout cycle.
      issue(1'b0, 32'h0380_0020, 32'h0);
      tick();
      respond(WR, 32'h0380_0020, 32'h0000_0001);
      check("op_stray", 32'(stray_cnt), 32'd3);
      repeat (14) tick();
      respond(RD_RSP, 32'h0380_0020, 32'h0000_5A5A);
      check("col_vld",   32'(core_rsp_vld), 32'd1);
      check("col_err",   32'(core_rsp_err), 32'd0);
      check("col_dat",   core_rsp_dat,      32'h0000_5A5A);
      check("col_to",    32'(timeout_cnt),  32'd1);
      held = core_rsp_dat;
      for (int k = 0; k < 4; k++) begin
         tick();
         check("bp_vld",  32'(core_rsp_vld), 32'd1);
         check("bp_dat",  core_rsp_dat,      held);
         check("bp_busy", 32'(busy),         32'd1);
         check("bp_rdy",  32'(core_req_rdy), 32'd0);
      end
      take_rsp();
      check("bp_done", 32'(core_rsp_vld), 32'd0);

      // Reset while waiting; the in-flight response arrives afterwards and counts as stray.
      issue(1'b0, 32'h0380_0030, 32'h0);
      tick();
      tick();
      check("rw_busy_pre", 32'(busy), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("rw_busy",  32'(busy),         32'd0);
      check("rw_rdy",   32'(core_req_rdy), 32'd1);
      check("rw_to",    32'(timeout_cnt),  32'd0);
      check("rw_stray", 32'(stray_cnt),    32'd0);
      tick();
      rst_n = 1'b1;
      tick();
      respond(RD_RSP, 32'h0380_0030, 32'h0000_0042);
      check("rw_late_stray", 32'(stray_cnt),    32'd1);
      check("rw_late_vld",   32'(core_rsp_vld), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      errors++;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1);
   end

endmodule
